// File: rtl/hilo_mul_seq_if.sv
// Bundle between the CPU pipeline and the HI/LO multiply stage,
// including the operand/product path to the external combinational multiplier.
interface hilo_mul_seq_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [63:0] mul_product;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wr_data;
  logic        hilo_rd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output start, op_a, op_b, mul_product, hi_we, lo_we, wr_data, hilo_rd,
    input  mul_x, mul_y, hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op_a, op_b, mul_product, hi_we, lo_we, wr_data, hilo_rd,
    output mul_x, mul_y, hi, lo, busy, done, stall
  );
endinterface

// File: rtl/hilo_mul_seq.sv
// Holds operands on the Booth multiplier for a fixed settle window, then
// captures the 64-bit product into HI/LO; also serves mthi/mtlo and read stalls.
module hilo_mul_seq #(
  parameter int MUL_LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  hilo_mul_seq_if.slave  bus
);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  logic [31:0] mul_x_reg, mul_x_next;
  logic [31:0] mul_y_reg, mul_y_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        done_reg, done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      mul_x_reg <= '0;
      mul_y_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      mul_x_reg <= mul_x_next;
      mul_y_reg <= mul_y_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    mul_x_next = mul_x_reg;
    mul_y_next = mul_y_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          mul_x_next = bus.op_a;
          mul_y_next = bus.op_b;
          count_next = 4'(MUL_LATENCY - 1);
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (count_reg == '0) begin
          hi_next    = bus.mul_product[63:32];
          lo_next    = bus.mul_product[31:0];
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Direct writes are applied last so they override a same-edge capture.
    if (bus.hi_we) hi_next = bus.wr_data;
    if (bus.lo_we) lo_next = bus.wr_data;
  end

  assign bus.mul_x = mul_x_reg;
  assign bus.mul_y = mul_y_reg;
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign bus.busy  = (state_reg == SETTLE);
  assign bus.done  = done_reg;
  assign bus.stall = bus.hilo_rd & ((state_reg == SETTLE) | ((state_reg == IDLE) & bus.start));

endmodule

// File: tb/tb_hilo_mul_seq.sv
// Self-checking bench: table of signed products through a latency-2 instance
// with a result scoreboard, plus hand sequences for corner cases and a latency-1 instance.
module tb_hilo_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hilo_mul_seq_if bus ();
  hilo_mul_seq_if bus1 ();

  // Behavioural stand-in for the combinational Booth multiplier.
  assign bus.mul_product  = 64'($signed(bus.mul_x)) * 64'($signed(bus.mul_y));
  assign bus1.mul_product = 64'($signed(bus1.mul_x)) * 64'($signed(bus1.mul_y));

  hilo_mul_seq #(.MUL_LATENCY(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  hilo_mul_seq #(.MUL_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        vecs[8];
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One clock edge, then scoreboard any result that the edge produced.
  task automatic step();
    logic [63:0] e;
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", bus.hi, bus.lo);
      end else begin
        e = exp_q.pop_front();
        $display("result hi=%h lo=%h (expected %h_%h)", bus.hi, bus.lo, e[63:32], e[31:0]);
        check32("sb_hi", bus.hi, e[63:32]);
        check32("sb_lo", bus.lo, e[31:0]);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy === 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (bus.busy === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within %0d cycles", budget);
    end
  endtask

  initial begin
    int d0;

    vecs[0] = '{32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    vecs[3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[5] = '{32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    vecs[6] = '{32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
    vecs[7] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    bus.start = 0; bus.op_a = 0; bus.op_b = 0; bus.hi_we = 0; bus.lo_we = 0;
    bus.wr_data = 0; bus.hilo_rd = 0;
    bus1.start = 0; bus1.op_a = 0; bus1.op_b = 0; bus1.hi_we = 0; bus1.lo_we = 0;
    bus1.wr_data = 0; bus1.hilo_rd = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check32("rst_hi", bus.hi, 32'h0);
    check32("rst_lo", bus.lo, 32'h0);
    check32("rst_mul_x", bus.mul_x, 32'h0);
    check32("rst_busy", 32'(bus.busy), 32'h0);
    check32("rst_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    step();

    // Table: each start is issued in the previous done cycle (back-to-back).
    for (int i = 0; i < 8; i++) begin
      bus.start = 1; bus.op_a = vecs[i].a; bus.op_b = vecs[i].b;
      exp_q.push_back({vecs[i].hi, vecs[i].lo});
      d0 = done_cnt;
      step();
      bus.start = 0;
      check32($sformatf("v%0d_busy_e0", i), 32'(bus.busy), 32'h1);
      check32($sformatf("v%0d_mul_x", i), bus.mul_x, vecs[i].a);
      check32($sformatf("v%0d_mul_y", i), bus.mul_y, vecs[i].b);
      step();
      check32($sformatf("v%0d_busy_e1", i), 32'(bus.busy), 32'h1);
      check32($sformatf("v%0d_done_e1", i), 32'(bus.done), 32'h0);
      step();
      check32($sformatf("v%0d_done_e2", i), 32'(bus.done), 32'h1);
      check32($sformatf("v%0d_busy_e2", i), 32'(bus.busy), 32'h0);
      check32($sformatf("v%0d_ndone", i), 32'(done_cnt - d0), 32'h1);
    end
    step();

    // Start held through SETTLE with other operands: ignored.
    bus.start = 1; bus.op_a = 32'd3; bus.op_b = 32'd4;
    exp_q.push_back(64'd12);
    d0 = done_cnt;
    step();
    bus.op_a = 32'd100; bus.op_b = 32'd200;
    step();
    check32("hold_mul_x", bus.mul_x, 32'd3);
    check32("hold_mul_y", bus.mul_y, 32'd4);
    step();
    bus.start = 0;
    step();
    step();
    check32("hold_ndone", 32'(done_cnt - d0), 32'h1);
    check32("hold_busy", 32'(bus.busy), 32'h0);

    // lo_we on the capture edge wins for LO only.
    bus.start = 1; bus.op_a = 32'd5; bus.op_b = 32'd6;
    step();
    bus.start = 0;
    step();
    bus.lo_we = 1; bus.wr_data = 32'h12345678;
    exp_q.push_back({32'h00000000, 32'h12345678});
    step();
    bus.lo_we = 0;
    check32("lowe_done", 32'(bus.done), 32'h1);
    step();

    // hi_we before capture takes effect, then the product overwrites it.
    bus.start = 1; bus.op_a = 32'd5; bus.op_b = 32'd6;
    exp_q.push_back(64'd30);
    step();
    bus.start = 0; bus.hi_we = 1; bus.wr_data = 32'hDEADBEEF;
    step();
    bus.hi_we = 0;
    check32("hiwe_mid", bus.hi, 32'hDEADBEEF);
    step();
    check32("hiwe_final", bus.hi, 32'h0);
    step();

    // Direct writes in IDLE: both enables, no done pulse.
    bus.hi_we = 1; bus.lo_we = 1; bus.wr_data = 32'hA5A55A5A;
    step();
    bus.hi_we = 0; bus.lo_we = 0;
    check32("mt_hi", bus.hi, 32'hA5A55A5A);
    check32("mt_lo", bus.lo, 32'hA5A55A5A);
    check32("mt_done", 32'(bus.done), 32'h0);

    // Read-hazard stall.
    bus.hilo_rd = 1;
    #1;
    check32("stall_idle", 32'(bus.stall), 32'h0);
    bus.start = 1; bus.op_a = 32'hFFFFFFFE; bus.op_b = 32'd3;
    #1;
    check32("stall_start", 32'(bus.stall), 32'h1);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
    step();
    bus.start = 0;
    check32("stall_busy0", 32'(bus.stall), 32'h1);
    step();
    check32("stall_busy1", 32'(bus.stall), 32'h1);
    step();
    check32("stall_done_cyc", 32'(bus.stall), 32'h0);
    check32("stall_done", 32'(bus.done), 32'h1);
    bus.hilo_rd = 0;

    // Asynchronous reset mid-SETTLE aborts the multiply.
    bus.start = 1; bus.op_a = 32'd9; bus.op_b = 32'd9;
    step();
    bus.start = 0;
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check32("arst_hi", bus.hi, 32'h0);
    check32("arst_lo", bus.lo, 32'h0);
    check32("arst_busy", 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step();
    check32("arst_nodone", 32'(done_cnt - d0), 32'h0);
    check32("arst_lo_after", bus.lo, 32'h0);

    // Latency-1 instance: capture on the edge after the start edge.
    bus1.start = 1; bus1.op_a = 32'hFFFFFFFC; bus1.op_b = 32'd5;
    step();
    bus1.start = 0;
    check32("l1_busy", 32'(bus1.busy), 32'h1);
    check32("l1_done_e0", 32'(bus1.done), 32'h0);
    step();
    check32("l1_done_e1", 32'(bus1.done), 32'h1);
    check32("l1_hi", bus1.hi, 32'hFFFFFFFF);
    check32("l1_lo", bus1.lo, 32'hFFFFFFEC);
    check32("l1_busy_e1", 32'(bus1.busy), 32'h0);
    $display("result l1 hi=%h lo=%h", bus1.hi, bus1.lo);

    wait_idle(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending results expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_mul_seq.md
Name: hilo_mul_seq

Overview:
- Sequential control and result-capture stage directly downstream of the combinational Booth multiplier (`alu_mul`).
- Latches the two operands on a start request and holds them on the multiplier inputs for a fixed multi-cycle settle window.
- Captures the 64-bit signed product into the architectural HI/LO registers.
- Provides busy/done handshake, direct HI/LO writes (mthi/mtlo) and a read-hazard stall to the CPU pipeline.

Parameters:
- MUL_LATENCY, 2, number of clock edges from operand latch to product capture; legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply of op_a * op_b (sampled only in IDLE)
- op_a  input  32  multiplicand (signed two's complement)
- op_b  input  32  multiplier (signed two's complement)
- mul_x  output  32  registered operand driven to multiplier x input
- mul_y  output  32  registered operand driven to multiplier y input
- mul_product  input  64  signed product returned from multiplier
- hi_we  input  1  direct write enable for HI (mthi)
- lo_we  input  1  direct write enable for LO (mtlo)
- wr_data  input  32  data for direct HI/LO write
- hilo_rd  input  1  pipeline is reading HI or LO this cycle (mfhi/mflo)
- hi  output  32  HI register (product[63:32])
- lo  output  32  LO register (product[31:0])
- busy  output  1  multiply in progress
- done  output  1  one-cycle pulse, HI/LO updated by multiply
- stall  output  1  pipeline stall request

Behaviour:
- Reset: clk and rst_n are the single clock and reset; reset is asynchronous and active-low.
- While rst_n=0:
  - state=IDLE, counter=0.
  - mul_x, mul_y, hi and lo are all 0.
  - busy=0, done=0.
- Reset asserted mid-operation aborts the multiply; no capture occurs after release.
- States: IDLE, SETTLE. busy = (state==SETTLE), registered.
- IDLE:
  - start=1 at edge E0 latches op_a into mul_x and op_b into mul_y.
  - Loads counter with MUL_LATENCY-1 and goes to SETTLE.
  - start=0 holds IDLE.
- SETTLE:
  - mul_x and mul_y are held constant; start is ignored (no queuing).
  - Each edge with counter>0 decrements the counter.
  - The edge with counter==0 captures hi=mul_product[63:32] and lo=mul_product[31:0], sets done=1 and returns to IDLE.
- Timing: capture occurs at edge E0+MUL_LATENCY.
  - busy is high for the MUL_LATENCY cycles following E0.
  - done is high for exactly the one cycle after the capture edge.
- Back-to-back: start asserted in the done cycle is accepted; the next result follows MUL_LATENCY edges later.
- mul_x and mul_y retain their last values in IDLE.
- Product is used as-is (signed 64-bit); no sign or width conversion in this block.
- Direct writes: hi_we loads hi<=wr_data and lo_we loads lo<=wr_data on the edge, in any state.
  - Both enables high loads both registers with wr_data.
- Simultaneous events:
  - Direct write on the capture edge: the direct write wins for the enabled register; the other register takes the product half.
  - Direct write during SETTLE before the capture edge: it takes effect, then is overwritten by the product at capture.
- stall = hilo_rd & (busy | (state==IDLE & start)); combinational. It prevents mfhi/mflo from reading stale HI/LO.
- done is not asserted for direct writes.

Test Plan:
- Reset then 7 * -3 (op_a=0x00000007, op_b=0xFFFFFFFD), MUL_LATENCY=2 -> busy for 2 cycles, done pulse in the cycle after the 2nd edge, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000; then 0x7FFFFFFF * 0xFFFFFFFF with start in the done cycle -> hi=0xFFFFFFFF, lo=0x80000001 exactly 2 edges later.
- Start held high during SETTLE with different operands -> mul_x and mul_y unchanged, only one done pulse, result from the first operands only.
- lo_we=1 with wr_data=0x12345678 on the capture edge of 5*6 -> lo=0x12345678, hi=0x00000000, done=1; hi_we=1 with wr_data=0xDEADBEEF one cycle before capture -> hi overwritten by product.
- hilo_rd=1 while busy -> stall=1 every busy cycle, stall=0 in the done cycle and in IDLE without start; hilo_rd=1 with start in IDLE -> stall=1.
- rst_n low for 1 cycle mid-SETTLE -> hi=lo=0 and busy=0 immediately (asynchronous), no done pulse afterwards; MUL_LATENCY=1 build -> capture on the edge after the start edge.
